// File: rtl/ltc_pkg.sv
// ltc_pkg: shared constants and types for the LTC 2-lane DDR LVDS emulator.
// Imported by the sample interface, the FIFO and the transmitter top.
package ltc_pkg;

  localparam int LTC_LANES = 2;
  localparam int LTC_WORD_W = 16;
  localparam int LTC_SLOTS = 8;
  localparam logic [15:0] LTC_TP_DEFAULT = 16'h3DDA;

  typedef logic [LTC_WORD_W-1:0] ltc_sample_t;
  typedef logic [$clog2(LTC_SLOTS)-1:0] ltc_slot_t;

endpackage

// File: rtl/ltc_lvds_tx_if.sv
// ltc_lvds_tx_if: valid/ready sample stream into the LVDS emulator.
// master drives samples, slave accepts them.
interface ltc_lvds_tx_if;
  import ltc_pkg::*;

  logic        s_valid;
  logic        s_ready;
  ltc_sample_t s_data;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );

endinterface

// File: rtl/ltc_sample_fifo.sv
// ltc_sample_fifo: small synchronous sample buffer.
// Pushes are refused when full; pops are ignored when empty.
module ltc_sample_fifo
  import ltc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_valid,
  input  ltc_sample_t push_data,
  input  logic        pop,
  output ltc_sample_t head,
  output logic        empty,
  output logic        full
);

  localparam int AW = $clog2(DEPTH);

  ltc_sample_t    mem [DEPTH];
  logic [AW-1:0]  wr_q;
  logic [AW-1:0]  rd_q;
  logic [AW:0]    cnt_q;
  logic           do_push;
  logic           do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_push = push_valid & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= push_data;
  end

endmodule

// File: rtl/ltc_lvds_tx.sv
// ltc_lvds_tx: serializes 16-bit samples onto two DDR LVDS lanes
// with FR and DCO, one sys_clk cycle per bit slot.
module ltc_lvds_tx
  import ltc_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter ltc_sample_t TP_DEFAULT = LTC_TP_DEFAULT
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  ltc_lvds_tx_if.slave s,
  input  logic         tp_en,
  input  ltc_sample_t  tp_value,
  output logic         out_a,
  output logic         out_b,
  output logic         fr,
  output logic         dco,
  output logic         frame_start,
  output logic         underflow
);

  ltc_slot_t   slot_q;
  ltc_slot_t   slot_nxt;
  ltc_sample_t sh_q;
  ltc_sample_t last_q;
  ltc_sample_t head;
  ltc_sample_t word;
  logic        run_q;
  logic        empty;
  logic        full;
  logic        load;
  logic        pop;

  ltc_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .push_valid (s.s_valid & s.s_ready),
    .push_data  (s.s_data),
    .pop        (pop),
    .head       (head),
    .empty      (empty),
    .full       (full)
  );

  // run_q keeps s_ready low until the first edge after reset release
  assign s.s_ready = run_q & ~full;
  assign slot_nxt  = slot_q + 1'b1;
  assign load      = &slot_q;
  assign pop       = load & ~tp_en & ~empty;

  always_comb begin
    word = sh_q;
    if (load) begin
      if (tp_en)       word = tp_value;
      else if (!empty) word = head;
      else             word = last_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      slot_q      <= '1;
      sh_q        <= TP_DEFAULT;
      last_q      <= '0;
      run_q       <= 1'b0;
      out_a       <= 1'b0;
      out_b       <= 1'b0;
      fr          <= 1'b0;
      dco         <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      slot_q      <= slot_nxt;
      run_q       <= 1'b1;
      sh_q        <= word << LTC_LANES;
      out_a       <= word[LTC_WORD_W-1];
      out_b       <= word[LTC_WORD_W-2];
      fr          <= ~slot_nxt[2];
      dco         <= slot_nxt[0];
      frame_start <= (slot_nxt == '0);
      underflow   <= load & ~tp_en & empty;
      if (pop) last_q <= head;
    end
  end

endmodule

// File: tb/tb_ltc_lvds_tx.sv
// tb_ltc_lvds_tx: directed bench with a frame scoreboard for ltc_lvds_tx.
// Expected frames are queued at each load edge and checked slot by slot.
module tb_ltc_lvds_tx;
  import ltc_pkg::*;

  typedef struct packed {
    logic [15:0] w;
    logic        uf;
  } frm_t;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        tp_en;
  logic [15:0] tp_value;
  logic        out_a;
  logic        out_b;
  logic        fr;
  logic        dco;
  logic        frame_start;
  logic        underflow;

  ltc_lvds_tx_if s_if ();

  ltc_lvds_tx #(
    .FIFO_DEPTH (4),
    .TP_DEFAULT (16'h3DDA)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .s           (s_if.slave),
    .tp_en       (tp_en),
    .tp_value    (tp_value),
    .out_a       (out_a),
    .out_b       (out_b),
    .fr          (fr),
    .dco         (dco),
    .frame_start (frame_start),
    .underflow   (underflow)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [2:0]  m_slot;
  logic        m_rdy;
  logic [15:0] m_last;
  logic [15:0] m_fifo [$];
  frm_t        exp_q [$];
  frm_t        cur;

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_zero();
    chk("rst_out_a", 16'(out_a), 16'h0);
    chk("rst_out_b", 16'(out_b), 16'h0);
    chk("rst_fr", 16'(fr), 16'h0);
    chk("rst_dco", 16'(dco), 16'h0);
    chk("rst_fs", 16'(frame_start), 16'h0);
    chk("rst_uf", 16'(underflow), 16'h0);
    chk("rst_ready", 16'(s_if.s_ready), 16'h0);
  endtask

  task automatic model_reset();
    m_slot = 3'd7;
    m_rdy  = 1'b0;
    m_last = 16'h0;
    m_fifo.delete();
    exp_q.delete();
    cur = '0;
  endtask

  task automatic step();
    frm_t        f;
    logic        acc;
    logic [15:0] w;
    int          k;
    acc = s_if.s_valid && m_rdy;
    if (m_slot == 3'd7) begin
      if (tp_en) begin
        f = '{w: tp_value, uf: 1'b0};
      end else if (m_fifo.size() != 0) begin
        w = m_fifo.pop_front();
        m_last = w;
        f = '{w: w, uf: 1'b0};
      end else begin
        f = '{w: m_last, uf: 1'b1};
      end
      exp_q.push_back(f);
    end
    if (acc) m_fifo.push_back(s_if.s_data);
    @(posedge sys_clk);
    #1;
    m_slot = m_slot + 3'd1;
    m_rdy  = (m_fifo.size() < 4);
    if (m_slot == 3'd0) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL sb_empty: observed 0 entries expected 1");
      end
      if (exp_q.size() != 0) cur = exp_q.pop_front();
    end
    k = int'(m_slot);
    chk("s_ready", 16'(s_if.s_ready), 16'(m_rdy));
    chk("fr", 16'(fr), 16'(m_slot < 3'd4));
    chk("dco", 16'(dco), 16'(m_slot[0]));
    chk("frame_start", 16'(frame_start), 16'(m_slot == 3'd0));
    chk("underflow", 16'(underflow), 16'(m_slot == 3'd0 && cur.uf));
    chk("out_a", 16'(out_a), 16'(cur.w[15-2*k]));
    chk("out_b", 16'(out_b), 16'(cur.w[14-2*k]));
  endtask

  task automatic push_word(logic [15:0] w);
    logic acc;
    logic done;
    done = 1'b0;
    s_if.s_valid = 1'b1;
    s_if.s_data  = w;
    for (int n = 0; n < 32 && !done; n++) begin
      acc = m_rdy;
      step();
      if (acc) done = 1'b1;
    end
    s_if.s_valid = 1'b0;
    chk("push_timeout", 16'(done), 16'h1);
  endtask

  task automatic wait_slot(logic [2:0] k);
    for (int n = 0; n < 16 && m_slot != k; n++) step();
  endtask

  logic [15:0] burst [5];
  int          idx;
  logic        seen;
  logic        acc_b;

  initial begin
    burst[0] = 16'h1111;
    burst[1] = 16'h2222;
    burst[2] = 16'h3333;
    burst[3] = 16'h4444;
    burst[4] = 16'h1234;
    sys_rst_n    = 1'b0;
    tp_en        = 1'b0;
    tp_value     = 16'h0;
    s_if.s_valid = 1'b0;
    s_if.s_data  = 16'h0;
    model_reset();

    repeat (3) @(posedge sys_clk);
    #1;
    chk_zero();
    sys_rst_n = 1'b1;

    // idle after reset: held sample 0 with underflow each frame
    repeat (16) step();

    tp_en    = 1'b1;
    tp_value = 16'h3DDA;
    push_word(16'h5A5A);
    repeat (8) step();
    tp_value = 16'hC0DE;
    repeat (12) step();
    tp_en = 1'b0;

    push_word(16'h8001);
    push_word(16'hFFFF);
    repeat (40) step();

    wait_slot(3'd0);
    idx  = 0;
    seen = 1'b0;
    s_if.s_valid = 1'b1;
    for (int n = 0; n < 40 && idx < 5; n++) begin
      s_if.s_data = burst[idx];
      acc_b = m_rdy;
      step();
      if (acc_b) idx++;
      if (idx == 4 && !seen) begin
        seen = 1'b1;
        chk("burst_ready_drop", 16'(s_if.s_ready), 16'h0);
      end
    end
    s_if.s_valid = 1'b0;
    chk("burst_accepted", 16'(idx), 16'd5);

    // drain the burst, then hold 16'h1234 with underflow
    repeat (64) step();

    push_word(16'hC3C3);
    push_word(16'h3C3C);
    wait_slot(3'd3);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk_zero();
    model_reset();
    @(posedge sys_clk);
    #1;
    chk_zero();
    sys_rst_n = 1'b1;
    repeat (24) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
